// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide controller: request opcodes,
// FSM states and the divide iteration count.
package muldiv_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_ctrl_div_core.sv
// Iterative unsigned restoring divider: one quotient bit per step, MSB first.
// The dividend shifts out of the quotient register into the partial remainder.
module div_core (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] quo_reg;
  logic [31:0] rem_reg;
  logic [31:0] dvs_reg;
  logic [32:0] rem_shift;
  logic [33:0] trial;
  logic        fits;

  // A successful trial always leaves a value below the divisor, so it must fit in 32 bits.
  always_comb begin
    rem_shift = {rem_reg, quo_reg[31]};
    trial     = {1'b0, rem_shift} - {2'b00, dvs_reg};
    fits      = (trial[33:32] == 2'b00);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      quo_reg <= '0;
      rem_reg <= '0;
      dvs_reg <= '0;
    end else if (start) begin
      quo_reg <= dividend;
      rem_reg <= '0;
      dvs_reg <= divisor;
    end else if (step) begin
      rem_reg <= fits ? trial[31:0] : rem_shift[31:0];
      quo_reg <= {quo_reg[30:0], fits};
    end
  end

  assign quotient  = quo_reg;
  assign remainder = rem_reg;

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner for the pipeline: single-cycle 33x33 multiply, 32-step restoring
// divide with a sign-fix cycle, and MTHI/MTLO writes from EX.
module muldiv_ctrl #(
  parameter int DIV_ITERS = muldiv_pkg::DIV_ITERS
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        cancel,
  output logic        req_ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  import muldiv_pkg::*;

  localparam logic [4:0] CNT_LAST = 5'(DIV_ITERS - 1);

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg;
  logic [32:0] mul_a_reg, mul_b_reg;
  logic        q_neg_reg, r_neg_reg;
  logic [31:0] hi_reg, lo_reg;
  logic        done_reg;

  logic        accept, op_signed, is_mul, is_div;
  logic        div_start, div_step;
  logic [31:0] abs_a, abs_b, quo, rem;
  logic [63:0] mul_a_ext, mul_b_ext, product;

  always_comb begin
    op_signed = (req_op == MD_MULT) || (req_op == MD_DIV);
    is_mul    = (req_op == MD_MULT) || (req_op == MD_MULTU);
    is_div    = (req_op == MD_DIV)  || (req_op == MD_DIVU);
    abs_a     = (op_signed && req_a[31]) ? -req_a : req_a;
    abs_b     = (op_signed && req_b[31]) ? -req_b : req_b;
    mul_a_ext = {{31{mul_a_reg[32]}}, mul_a_reg};
    mul_b_ext = {{31{mul_b_reg[32]}}, mul_b_reg};
    product   = mul_a_ext * mul_b_ext;
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    div_start  = 1'b0;
    div_step   = 1'b0;
    req_ready  = (state_reg == ST_IDLE);
    accept     = req_valid && req_ready && !cancel;
    case (state_reg)
      ST_IDLE: begin
        if (accept && is_mul) state_next = ST_MUL;
        if (accept && is_div) begin
          state_next = ST_DIV;
          div_start  = 1'b1;
        end
      end
      ST_MUL: state_next = ST_IDLE;
      ST_DIV: begin
        div_step = 1'b1;
        if (cnt_reg == CNT_LAST) state_next = ST_FIX;
      end
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (cancel) state_next = ST_IDLE;
  end

  div_core u_div_core (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start),
    .step      (div_step),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .quotient  (quo),
    .remainder (rem)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi_reg    <= '0;
      lo_reg    <= '0;
      done_reg  <= 1'b0;
      cnt_reg   <= '0;
      mul_a_reg <= '0;
      mul_b_reg <= '0;
      q_neg_reg <= 1'b0;
      r_neg_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        if (req_op == MD_MTHI) hi_reg <= req_a;
        if (req_op == MD_MTLO) lo_reg <= req_a;
        if (is_mul) begin
          mul_a_reg <= {op_signed & req_a[31], req_a};
          mul_b_reg <= {op_signed & req_b[31], req_b};
        end
        if (is_div) begin
          cnt_reg   <= '0;
          // A zero divisor keeps the all-ones quotient; the remainder fix restores A.
          q_neg_reg <= op_signed & (req_a[31] ^ req_b[31]) & (|req_b);
          r_neg_reg <= op_signed & req_a[31];
        end
      end
      if (state_reg == ST_DIV) cnt_reg <= cnt_reg + 5'd1;
      if (!cancel && state_reg == ST_MUL) begin
        {hi_reg, lo_reg} <= product;
        done_reg         <= 1'b1;
      end
      if (!cancel && state_reg == ST_FIX) begin
        lo_reg   <= q_neg_reg ? -quo : quo;
        hi_reg   <= r_neg_reg ? -rem : rem;
        done_reg <= 1'b1;
      end
    end
  end

  assign busy = ~req_ready;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: the driver queues expected HI/LO and completion
// cycle per MULT/DIV; a negedge monitor pops and compares on every done pulse.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        cancel;
  logic        req_ready, busy, done;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  muldiv_ctrl dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .cancel    (cancel),
    .req_ready (req_ready),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resetn && done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cyc=%0d hi=%h lo=%h", cyc, hi, lo);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (hi !== e.hi || lo !== e.lo || cyc != e.cyc) begin
          errors++;
          $display("FAIL %s: got hi=%h lo=%h cyc=%0d, want hi=%h lo=%h cyc=%0d",
                   e.name, hi, lo, cyc, e.hi, e.lo, e.cyc);
        end else begin
          $display("done  %-10s cyc=%0d hi=%h lo=%h", e.name, cyc, hi, lo);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end else begin
      $display("check %-16s cyc=%0d value=%h", name, cyc, act);
    end
  endtask

  // Presents one request for a single cycle once the controller is ready; returns T.
  task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit push, input logic [31:0] eh,
                       input logic [31:0] el, input int lat, output int t);
    int waited = 0;
    while (!req_ready && waited < 100) begin
      step();
      waited++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_ready_timeout: req_ready=%b, want 1", name, req_ready);
    end
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    t         = cyc;
    if (push) sb.push_back('{hi: eh, lo: el, cyc: t + lat, name: name});
    $display("issue %-10s cyc=%0d op=%0d a=%h b=%h", name, t, op, a, b);
    step();
    req_valid = 1'b0;
  endtask

  // Counts busy cycles after issue (bounded) and compares against the expected count.
  task automatic wait_idle(input string name, input int want_busy);
    int n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    chk({name, "_busy"}, 32'(n), 32'(want_busy));
  endtask

  initial begin
    int t;
    resetn    = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    cancel    = 1'b0;
    repeat (3) step();
    resetn = 1'b1;
    step();

    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_done",  32'(done),      32'd0);
    chk("rst_hi",    hi,             32'h0);
    chk("rst_lo",    lo,             32'h0);

    issue("mult",  3'd0, 32'hFFFF_FFFE, 32'd3, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 2, t);
    wait_idle("mult", 1);
    issue("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 1, 32'h0000_0002, 32'hFFFF_FFFA, 2, t);
    wait_idle("multu", 1);

    issue("divu", 3'd3, 32'd100, 32'd7, 1, 32'd2, 32'd14, 34, t);
    wait_idle("divu", 33);
    issue("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, t);
    wait_idle("div_neg", 33);
    issue("div_negb", 3'd2, 32'd7, 32'hFFFF_FFFE, 1, 32'd1, 32'hFFFF_FFFD, 34, t);
    wait_idle("div_negb", 33);
    issue("divu_by0", 3'd3, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, 34, t);
    wait_idle("divu_by0", 33);
    issue("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0, 32'h8000_0000, 34, t);
    wait_idle("div_ovf", 33);

    // Back-to-back MULTU: second is accepted in the cycle the first shows done.
    issue("multu_b1", 3'd1, 32'd2, 32'h0001_0000, 1, 32'h0, 32'h0002_0000, 2, t);
    issue("multu_b2", 3'd1, 32'h0001_0000, 32'h0001_0000, 1, 32'h1, 32'h0, 2, t);
    wait_idle("multu_b2", 1);
    step();

    // MTHI then MTLO on consecutive cycles.
    req_valid = 1'b1; req_op = 3'd4; req_a = 32'h1234_5678; req_b = '0;
    step();
    chk("mthi_hi",    hi,             32'h1234_5678);
    chk("mthi_ready", 32'(req_ready), 32'd1);
    req_op = 3'd5; req_a = 32'h9ABC_DEF0;
    step();
    req_valid = 1'b0;
    chk("mtlo_lo",    lo,             32'h9ABC_DEF0);
    chk("mtlo_hi",    hi,             32'h1234_5678);
    chk("mtlo_ready", 32'(req_ready), 32'd1);

    issue("reserved", 3'd6, 32'hDEAD_BEEF, 32'd1, 0, 32'h0, 32'h0, 0, t);
    chk("rsv_hi",    hi,             32'h1234_5678);
    chk("rsv_lo",    lo,             32'h9ABC_DEF0);
    chk("rsv_ready", 32'(req_ready), 32'd1);

    // Cancel a DIV at T+10.
    issue("mthi_a", 3'd4, 32'hAAAA_AAAA, 32'd0, 0, 32'h0, 32'h0, 0, t);
    issue("mtlo_a", 3'd5, 32'hAAAA_AAAA, 32'd0, 0, 32'h0, 32'h0, 0, t);
    issue("div_cxl", 3'd2, 32'd1000, 32'd3, 0, 32'h0, 32'h0, 0, t);
    while (cyc < t + 10) step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("cxl_ready", 32'(req_ready), 32'd1);
    chk("cxl_hi",    hi,             32'hAAAA_AAAA);
    chk("cxl_lo",    lo,             32'hAAAA_AAAA);
    repeat (40) step();
    chk("cxl_hi_late", hi, 32'hAAAA_AAAA);
    issue("multu_post", 3'd1, 32'd2, 32'd3, 1, 32'h0, 32'd6, 2, t);
    wait_idle("multu_post", 1);

    // A request held during cancel in IDLE is not accepted.
    step();
    req_valid = 1'b1; req_op = 3'd5; req_a = 32'h0000_0055; cancel = 1'b1;
    step();
    req_valid = 1'b0; cancel = 1'b0;
    chk("cxl_idle_lo",    lo,             32'd6);
    chk("cxl_idle_ready", 32'(req_ready), 32'd1);

    // Reset during a DIV at T+20.
    issue("divu_rst", 3'd3, 32'd100, 32'd7, 0, 32'h0, 32'h0, 0, t);
    while (cyc < t + 20) step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("rst2_hi",    hi,             32'h0);
    chk("rst2_lo",    lo,             32'h0);
    chk("rst2_ready", 32'(req_ready), 32'd1);
    chk("rst2_done",  32'(done),      32'd0);
    repeat (40) step();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide controller that owns the architectural HI/LO registers for the MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from EX through a valid/ready handshake. It sequences a single-cycle signed/unsigned multiply or a 32-iteration restoring divide, then writes HI/LO. EX stalls on `busy`; MFHI/MFLO read `hi`/`lo` directly.

## Interface

Parameters:
- `DIV_ITERS`, 32: restoring-divide iterations. Fixed at 32 for this design and not to be overridden.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  — rising-edge clock.
- `resetn`  in  1  — synchronous, active-low reset.
- `req_valid`  in  1  — request present.
- `req_op`  in  3  — operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 reserved.
- `req_a`  in  32  — rs value (dividend / multiplicand / MTHI-MTLO data).
- `req_b`  in  32  — rt value (divisor / multiplier).
- `cancel`  in  1  — exception flush; aborts any in-flight operation.
- `req_ready`  out  1  — controller idle, able to accept.
- `busy`  out  1  — equals `~req_ready`.
- `done`  out  1  — one-cycle pulse, high in the first cycle new MULT/DIV results are visible on `hi`/`lo`.
- `hi`  out  32  — HI register.
- `lo`  out  32  — LO register.

## Operation

- A request is accepted in cycle T when `req_valid & req_ready & ~cancel`.
- FSM states:
  - IDLE: `req_ready` = 1.
  - MUL: 1 cycle.
  - DIV: `DIV_ITERS` cycles; counter counts 0..31.
  - FIX: 1 cycle.
- Transitions:
  - IDLE→MUL on accepted op 0/1.
  - IDLE→DIV on accepted op 2/3.
  - MUL→IDLE.
  - DIV→FIX when counter = 31.
  - FIX→IDLE.
  - Any state→IDLE on `cancel`.
- MTHI/MTLO: HI (or LO) ← `req_a` at the end of cycle T. The FSM stays in IDLE and no `done` is raised.
- Reserved ops: accepted, with no effect and no `done`.
- MULT/MULTU:
  - Operands are latched at T and sign- or zero-extended to 33 bits.
  - The 66-bit product is computed in MUL; {HI,LO} ← product[63:0].
- DIV/DIVU:
  - At T, latch magnitudes |A| and |B|. For unsigned ops these are the raw values. |0x8000_0000| = 0x8000_0000 and fits in 32 bits.
  - Latch the quotient-sign flag (signed op & A[31]^B[31]) and the remainder-sign flag (signed op & A[31]).
  - Each DIV cycle does one restoring step: 33-bit partial remainder, shift in the next dividend bit, trial-subtract the divisor, set the quotient bit if the result is non-negative.
  - FIX negates the quotient and/or remainder per the flags, then writes LO ← quotient and HI ← remainder.
- Divide by zero is defined, not trapped:
  - Raw magnitudes give quotient 0xFFFF_FFFF and remainder |A|.
  - After FIX, LO = 0xFFFF_FFFF and HI = A, for both signed and unsigned ops; the sign fix is suppressed when B = 0.
  - Full latency still applies.
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF gives LO = 0x8000_0000, HI = 0 (natural wrap).
- `cancel`:
  - Next state is IDLE and HI/LO are unchanged.
  - No `done` is raised. Any `done` already high in the same cycle still completes, since HI/LO were already written.
- `resetn` low, including mid-operation: state IDLE, HI = LO = 0, `done` = 0, counter = 0.

## Timing

- Reset values:
  - `req_ready` = 1, `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0.
- MTHI/MTLO: new value visible at T+1.
- MULT/MULTU:
  - In MUL during T+1.
  - HI/LO visible and `done` = 1 at T+2.
  - `req_ready` = 1 at T+2.
- DIV/DIVU:
  - In DIV during T+1..T+32 and FIX at T+33.
  - HI/LO visible and `done` = 1 at T+34.
  - `req_ready` = 1 at T+34.
- A new request may be accepted in the same cycle `done` is high. Back-to-back MULTs therefore complete every 2 cycles.
- `hi`/`lo` are driven straight from registers, with no combinational path from `req_*`.

## Structure

- Package `muldiv_pkg` holds:
  - op encodings `MD_MULT`…`MD_MTLO`;
  - FSM state enum (IDLE, MUL, DIV, FIX);
  - the `DIV_ITERS` constant.
- Sub-module `div_core`: iterative unsigned restoring divider datapath.
  - Holds the partial remainder, quotient shift register and trial subtractor.
  - Controlled by `start` and `step` from the FSM.
  - Outputs the 32-bit quotient and remainder.
- The FSM, sign handling, multiplier and HI/LO registers stay in `muldiv_ctrl`.

## Test plan

- MULT A=0xFFFF_FFFE, B=3 → at T+2 `done`=1, HI=0xFFFF_FFFF, LO=0xFFFF_FFFA. MULTU with the same operands → HI=0x0000_0002, LO=0xFFFF_FFFA.
- DIVU A=100, B=7 → `busy` for T+1..T+33; at T+34 `done`=1, LO=14, HI=2. DIV A=0xFFFF_FFF9 (−7), B=2 → LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
- Divide edge cases:
  - DIVU A=5, B=0 → LO=0xFFFF_FFFF, HI=5 at T+34.
  - DIV A=0x8000_0000, B=0xFFFF_FFFF → LO=0x8000_0000, HI=0.
- MTHI 0x1234_5678 then MTLO 0x9ABC_DEF0 on consecutive cycles → HI and LO update at T+1 and T+2; `done` never asserts; `req_ready` stays 1.
- DIV started with HI=LO=0xAAAA_AAAA, then `cancel` at T+10:
  - `req_ready`=1 at T+11 and HI/LO stay 0xAAAA_AAAA.
  - No `done` within 40 cycles.
  - A following MULTU 2×3 gives LO=6.
- `resetn` low for 1 cycle at T+20 of a DIV → next cycle HI=LO=0, `req_ready`=1, `done`=0. `req_valid` held high during `cancel` in IDLE is not accepted.
